// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   MAX_DATA_BITS   = 9;
  localparam int   BIT_CNT_W       = 4;

  // Even parity makes the total count of ones even; odd parity inverts that bit.
  function automatic logic parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baudGenerator.sv
// Bit-timing source: toggles baudClk_o every baud_i+1 enabled cycles; holds 0 and reloads while disabled.
module baudGenerator (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] baud_i,
  output logic        baudClk_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q     <= baud_i;
      baudClk_o <= 1'b0;
    end else if (cnt_q == 16'd0) begin
      cnt_q     <= baud_i;
      baudClk_o <= ~baudClk_o;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits,
// timed by counting both edges of the baud generator's toggling output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 parityEn_i,
  input  logic                 parityOdd_i,
  output logic                 baudEn_o,
  input  logic                 baudClk_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  txState_t               state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   stop_cnt_q;
  logic                   baud_clk_q;
  logic                   half_cnt_q;
  logic                   tx_q;
  logic                   done_q;

  logic edge_det, bit_tick, accept, last_data, last_stop;

  assign edge_det  = baudClk_i ^ baud_clk_q;
  assign bit_tick  = edge_det & half_cnt_q;
  assign accept    = valid_i & ready_o;
  assign last_data = (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA:    if (bit_tick && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_tick) state_d = STOP;
      STOP:    if (bit_tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    busy_o   = ~ready_o;
    baudEn_o = ~ready_o;
    tx_o     = tx_q;
    done_o   = done_q;
  end

  // Edge detector, counters and the serial line register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q       <= UART_IDLE_LEVEL;
      done_q     <= 1'b0;
      baud_clk_q <= 1'b0;
      half_cnt_q <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Idle holds the detector cleared so the first bit is phase-locked to accept.
      if (state_q == IDLE) begin
        baud_clk_q <= 1'b0;
        half_cnt_q <= 1'b0;
      end else begin
        baud_clk_q <= baudClk_i;
        half_cnt_q <= half_cnt_q ^ edge_det;
      end

      unique case (state_q)
        IDLE: tx_q <= accept ? 1'b0 : UART_IDLE_LEVEL;
        START: if (bit_tick) begin
          tx_q      <= shift_q[0];
          bit_cnt_q <= '0;
        end
        DATA: if (bit_tick) begin
          if (last_data) begin
            tx_q       <= par_en_q ? par_bit_q : UART_IDLE_LEVEL;
            stop_cnt_q <= 1'b0;
          end else begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        PARITY: if (bit_tick) begin
          tx_q       <= UART_IDLE_LEVEL;
          stop_cnt_q <= 1'b0;
        end
        STOP: if (bit_tick) begin
          if (last_stop) done_q     <= 1'b1;
          else           stop_cnt_q <= stop_cnt_q + 1'b1;
        end
        default: tx_q <= UART_IDLE_LEVEL;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are always loaded on accept
  // before being observed, so resetting them would only add logic.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE) begin
      if (accept) begin
        shift_q   <= data_i;
        par_en_q  <= parityEn_i;
        par_bit_q <= parity(MAX_DATA_BITS'(data_i), parityOdd_i);
      end
    end else if (bit_tick && (state_q == START || state_q == DATA)) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: two instances (1 and 2 stop bits), each fed by a baudGenerator with baud_i=3.
module tb_uart_tx;

  typedef struct {
    logic [127:0] wave;
    int           len;
    bit           abort;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] valid_d = '0, pe_d = '0, po_d = '0;
  logic [7:0] data_d [2];
  logic [1:0] ready_w, en_w, bclk_w, tx_w, busy_w, done_w;

  frame_t q0[$], q1[$];
  int     sent[2];
  int     done_cnt[2];
  int     n_cmp = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  baudGenerator gen0 (.clk_i(clk), .rst_i(rst), .en_i(en_w[0]), .baud_i(16'd3), .baudClk_o(bclk_w[0]));
  baudGenerator gen1 (.clk_i(clk), .rst_i(rst), .en_i(en_w[1]), .baud_i(16'd3), .baudClk_o(bclk_w[1]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data_d[0]), .valid_i(valid_d[0]), .ready_o(ready_w[0]),
    .parityEn_i(pe_d[0]), .parityOdd_i(po_d[0]), .baudEn_o(en_w[0]), .baudClk_i(bclk_w[0]),
    .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data_d[1]), .valid_i(valid_d[1]), .ready_o(ready_w[1]),
    .parityEn_i(pe_d[1]), .parityOdd_i(po_d[1]), .baudEn_o(en_w[1]), .baudClk_i(bclk_w[1]),
    .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Expected line level for each cycle after the accept edge: the start bit is
  // one bit time plus one cycle, every later bit is 8 cycles.
  function automatic frame_t model(input logic [7:0] d, input logic pe, input logic po,
                                   input int stop_bits);
    frame_t f;
    int t    = 0;
    int ones = 0;
    f.wave  = '1;
    f.abort = 1'b0;
    for (int k = 0; k < 9; k++) f.wave[t++] = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 8; k++) f.wave[t++] = d[b];
      ones += int'(d[b]);
    end
    if (pe) for (int k = 0; k < 8; k++) f.wave[t++] = ((ones % 2) == 1) ^ po;
    for (int k = 0; k < 8 * stop_bits; k++) f.wave[t++] = 1'b1;
    f.len = t;
    return f;
  endfunction

  task automatic monitor(input int u);
    frame_t       e;
    logic [127:0] got;
    bit           ctl_ok, aborted, pending;
    int           n;
    pending = 1'b0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (rst || !(valid_d[u] && ready_w[u])) continue;
      n = (u == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        check("unexpected accept", 1, 0);
        continue;
      end
      if (u == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      got = '1; ctl_ok = 1'b1; aborted = 1'b0;
      for (int i = 0; i < e.len; i++) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        got[i] = tx_w[u];
        if (ready_w[u] || !busy_w[u] || !en_w[u] || done_w[u]) ctl_ok = 1'b0;
      end
      if (aborted) begin
        check("reset hit an unplanned frame", e.abort, 1);
        done_cnt[u]++;
        continue;
      end
      check(u == 0 ? "frame wave u0" : "frame wave u1", got, e.wave);
      check("ready/busy/baudEn during frame", ctl_ok, 1);
      @(negedge clk);
      check("done cycle {done,ready,busy,en,tx}",
            {done_w[u], ready_w[u], busy_w[u], en_w[u], tx_w[u]}, 5'b11001);
      done_cnt[u]++;
      pending = 1'b1;
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic send(input int u, input logic [7:0] d, input logic pe, input logic po,
                      input bit scramble, input bit keep_valid, input bit abort);
    frame_t f;
    bit     ok = 1'b0;
    f = model(d, pe, po, (u == 0) ? 1 : 2);
    f.abort = abort;
    if (u == 0) q0.push_back(f);
    else        q1.push_back(f);
    sent[u]++;
    data_d[u] = d; pe_d[u] = pe; po_d[u] = po; valid_d[u] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ready_w[u]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep_valid) valid_d[u] = 1'b0;
    if (scramble) begin
      for (int c = 0; c < 40; c++) begin
        data_d[u] = 8'($urandom);
        pe_d[u]   = 1'($urandom);
        po_d[u]   = 1'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_cnt[0] == sent[0] && done_cnt[1] == sent[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frames completed before timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    data_d[0] = '0; data_d[1] = '0;
    sent[0] = 0; sent[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset u0 {tx,ready,busy,en,done}", {tx_w[0], ready_w[0], busy_w[0], en_w[0], done_w[0]}, 5'b11000);
    check("reset u1 {tx,ready,busy,en,done}", {tx_w[1], ready_w[1], busy_w[1], en_w[1], done_w[1]}, 5'b11000);
    @(posedge clk); #1;

    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send(0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(0, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with valid held high; 0x22 is presented while 0x11 is on the line.
    send(0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    wait_idle();

    // Reset during data bit 3 (cycles 33..40 after accept).
    send(0, 8'hC6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (35) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("after mid-frame reset {tx,en,ready}", {tx_w[0], en_w[0], ready_w[0]}, 3'b101);
    @(posedge clk); #1;
    send(0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    for (int n = 0; n < 14; n++) begin
      send(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    wait_idle();

    check("scoreboard u0 drained", q0.size(), 0);
    check("scoreboard u1 drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
